// File: rtl/adma_engine.sv
// ADMA descriptor-driven DMA engine moving words between a RAM port and a FIFO port.
// Optional feature: define ADMA_INT_EN to enable the per-descriptor int_DAT pulse.
module adma_engine #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 64,
  parameter int DESC_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                            clk_in_COM,
  input  logic                            reset_in_COM,
  input  logic                            write_in_COM,
  input  logic [$clog2(DESC_DEPTH)-1:0]   desc_idx_COM,
  input  logic [ADDR_W+LEN_W+16-1:0]      addr_in_COM,
  input  logic                            error_in_COM,
  input  logic                            enable_transfer_mode_REG,
  input  logic                            dir_REG,
  input  logic [11:0]                     block_size_REG,
  input  logic                            stop_block_gap_REG,
  input  logic                            continue_block_gap_REG,
  input  logic [DATA_W-1:0]               data_in_RAM,
  input  logic [DATA_W-1:0]               data_in_FIFO,
  input  logic                            full_FIFO,
  input  logic                            empty_FIFO,
  output logic [ADDR_W-1:0]               addr_out_RAM,
  output logic [DATA_W-1:0]               data_out_RAM,
  output logic                            we_RAM,
  output logic [DATA_W-1:0]               data_out_FIFO,
  output logic                            push_FIFO,
  output logic                            pop_FIFO,
  output logic                            busy,
  output logic                            transfer_complete_DAT,
  output logic                            newDAT_DAT,
  output logic                            int_DAT,
  output logic                            error_DMA
);

  localparam int IDX_W  = $clog2(DESC_DEPTH);
  localparam int DESC_W = ADDR_W + LEN_W + 16;
  localparam int ENT_W  = ADDR_W + LEN_W + 5;
  localparam int CNT_W  = LEN_W + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FDS  = 3'd1;
  localparam logic [2:0] ST_CADR = 3'd2;
  localparam logic [2:0] ST_TFR  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  // Table entry keeps only the decoded fields: {addr, len, act, int, end, valid}.
  logic [ENT_W-1:0] desc_tbl [DESC_DEPTH];

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic [1:0]        d_act;
  logic              d_int, d_end, d_valid;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  count;
  logic [11:0]       blk;
  logic              dir_q;
  logic              resume_adv;

  logic        move, xfer, last, blk_hit, gap_req;
  logic [11:0] blk_next;
  logic        unused_attr;

  // NOTE: the descriptor table has no reset; it is plain storage that software fills before start.
  always_ff @(posedge clk_in_COM) begin
    if (!reset_in_COM && write_in_COM && state == ST_IDLE)
      desc_tbl[desc_idx_COM] <= {addr_in_COM[DESC_W-1 -: ADDR_W], addr_in_COM[16 +: LEN_W],
                                 addr_in_COM[5:4], addr_in_COM[2:0]};
  end

  assign move     = dir_q ? !full_FIFO : !empty_FIFO;
  assign xfer     = (state == ST_TFR) && !error_in_COM && move;
  assign last     = (count == CNT_W'(1));
  assign blk_next = blk + 12'd1;
  assign blk_hit  = (block_size_REG != 12'd0) && (blk_next == block_size_REG);
  assign gap_req  = blk_hit && stop_block_gap_REG && !continue_block_gap_REG;

  assign busy                  = (state != ST_IDLE);
  assign newDAT_DAT            = (state == ST_FDS)  && !error_in_COM;
  assign transfer_complete_DAT = (state == ST_DONE) && !error_in_COM;
  assign push_FIFO             = xfer && dir_q;
  assign pop_FIFO              = xfer && !dir_q;
  assign we_RAM                = xfer && !dir_q;
  assign addr_out_RAM          = xfer ? addr_cnt : '0;
  assign data_out_FIFO         = (xfer && dir_q)  ? data_in_RAM  : '0;
  assign data_out_RAM          = (xfer && !dir_q) ? data_in_FIFO : '0;

`ifdef ADMA_INT_EN
  assign int_DAT     = xfer && last && d_int;
  assign unused_attr = ^{addr_in_COM[15:6], addr_in_COM[3]};
`else
  assign int_DAT     = 1'b0;
  assign unused_attr = ^{addr_in_COM[15:6], addr_in_COM[3], d_int};
`endif

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_in_COM) begin
    if (reset_in_COM) begin
      state      <= ST_IDLE;
      idx        <= '0;
      d_addr     <= '0;
      d_len      <= '0;
      d_act      <= '0;
      d_int      <= 1'b0;
      d_end      <= 1'b0;
      d_valid    <= 1'b0;
      addr_cnt   <= '0;
      count      <= '0;
      blk        <= '0;
      dir_q      <= 1'b0;
      resume_adv <= 1'b0;
      error_DMA  <= 1'b0;
    end else if (state != ST_IDLE && error_in_COM) begin
      state     <= ST_IDLE;
      error_DMA <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_transfer_mode_REG) begin
            idx       <= '0;
            blk       <= '0;
            error_DMA <= 1'b0;
            state     <= ST_FDS;
          end
        end
        ST_FDS: begin
          {d_addr, d_len, d_act, d_int, d_end, d_valid} <= desc_tbl[idx];
          state <= ST_CADR;
        end
        ST_CADR: begin
          if (!d_valid) begin
            error_DMA <= 1'b1;
            state     <= ST_IDLE;
          end else if (d_act == ACT_TRAN) begin
            addr_cnt <= d_addr;
            count    <= (d_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, d_len};
            dir_q    <= dir_REG;
            state    <= ST_TFR;
          end else if (d_act == ACT_LINK) begin
            idx   <= d_addr[IDX_W-1:0];
            state <= ST_FDS;
          end else begin
            state <= d_end ? ST_DONE : ST_FDS;
            if (!d_end) idx <= idx + IDX_W'(1);
          end
        end
        ST_TFR: begin
          if (xfer) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            count    <= count - CNT_W'(1);
            blk      <= blk_hit ? 12'd0 : blk_next;
            if (gap_req) begin
              resume_adv <= last;
              state      <= ST_GAP;
            end else if (last) begin
              state <= d_end ? ST_DONE : ST_FDS;
              if (!d_end) idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (continue_block_gap_REG) begin
            if (resume_adv) begin
              state <= d_end ? ST_DONE : ST_FDS;
              if (!d_end) idx <= idx + IDX_W'(1);
            end else begin
              state <= ST_TFR;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adma_engine.sv
// Scoreboard bench for adma_engine: expected RAM/FIFO strobes are queued at stimulus time
// and popped by a negedge monitor.
module tb_adma_engine;

  logic        clk_in_COM = 1'b0;
  logic        reset_in_COM = 1'b1;
  logic        write_in_COM = 1'b0;
  logic [2:0]  desc_idx_COM = '0;
  logic [95:0] addr_in_COM = '0;
  logic        error_in_COM = 1'b0;
  logic        enable_transfer_mode_REG = 1'b0;
  logic        dir_REG = 1'b1;
  logic [11:0] block_size_REG = '0;
  logic        stop_block_gap_REG = 1'b0;
  logic        continue_block_gap_REG = 1'b0;
  logic [7:0]  data_in_RAM, data_in_FIFO;
  logic        full_FIFO = 1'b0;
  logic        empty_FIFO;
  logic [63:0] addr_out_RAM;
  logic [7:0]  data_out_RAM, data_out_FIFO;
  logic        we_RAM, push_FIFO, pop_FIFO, busy;
  logic        transfer_complete_DAT, newDAT_DAT, int_DAT, error_DMA;

  logic        empty_base = 1'b1;
  logic        empty_toggle = 1'b0;
  logic        tog = 1'b0;
  logic [7:0]  fifo_data = 8'h40;

  int vectors = 0;
  int miscompares = 0;
  int pushes = 0, writes = 0, newdat_cnt = 0, done_cnt = 0, int_cnt = 0;
  logic [71:0] rd_q[$];
  logic [71:0] wr_q[$];

  adma_engine dut (
    .clk_in_COM(clk_in_COM), .reset_in_COM(reset_in_COM), .write_in_COM(write_in_COM),
    .desc_idx_COM(desc_idx_COM), .addr_in_COM(addr_in_COM), .error_in_COM(error_in_COM),
    .enable_transfer_mode_REG(enable_transfer_mode_REG), .dir_REG(dir_REG),
    .block_size_REG(block_size_REG), .stop_block_gap_REG(stop_block_gap_REG),
    .continue_block_gap_REG(continue_block_gap_REG), .data_in_RAM(data_in_RAM),
    .data_in_FIFO(data_in_FIFO), .full_FIFO(full_FIFO), .empty_FIFO(empty_FIFO),
    .addr_out_RAM(addr_out_RAM), .data_out_RAM(data_out_RAM), .we_RAM(we_RAM),
    .data_out_FIFO(data_out_FIFO), .push_FIFO(push_FIFO), .pop_FIFO(pop_FIFO), .busy(busy),
    .transfer_complete_DAT(transfer_complete_DAT), .newDAT_DAT(newDAT_DAT), .int_DAT(int_DAT),
    .error_DMA(error_DMA)
  );

  always #5 clk_in_COM = ~clk_in_COM;

  function automatic logic [7:0] ram_f(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign data_in_RAM  = ram_f(addr_out_RAM);
  assign data_in_FIFO = fifo_data;
  assign empty_FIFO   = empty_toggle ? tog : empty_base;

  always @(posedge clk_in_COM) begin
    tog <= ~tog;
    if (pop_FIFO) fifo_data <= fifo_data + 8'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in_COM) begin
    if (!reset_in_COM) begin
      logic [71:0] e;
      if (newDAT_DAT) newdat_cnt++;
      if (transfer_complete_DAT) done_cnt++;
      if (int_DAT) begin
        int_cnt++;
        check("int_with_strobe", 64'(push_FIFO | we_RAM), 64'd1);
      end
      if (push_FIFO) begin
        pushes++;
        check("push_not_full", 64'(full_FIFO), 64'd0);
        if (rd_q.size() == 0) check("push_unexpected", 64'(push_FIFO), 64'd0);
        else begin
          e = rd_q.pop_front();
          check("push_addr", addr_out_RAM, e[71:8]);
          check("push_data", 64'(data_out_FIFO), 64'(e[7:0]));
        end
      end
      if (we_RAM) begin
        writes++;
        check("we_not_empty", 64'(empty_FIFO), 64'd0);
        check("pop_with_we", 64'(pop_FIFO), 64'd1);
        if (wr_q.size() == 0) check("we_unexpected", 64'(we_RAM), 64'd0);
        else begin
          e = wr_q.pop_front();
          check("we_addr", addr_out_RAM, e[71:8]);
          check("we_data", 64'(data_out_RAM), 64'(e[7:0]));
        end
      end
    end
  end

  task automatic write_desc(input logic [2:0] i, input logic [63:0] a, input logic [15:0] len,
                            input logic [15:0] attr);
    @(posedge clk_in_COM); #1;
    write_in_COM = 1'b1; desc_idx_COM = i; addr_in_COM = {a, len, attr};
    @(posedge clk_in_COM); #1;
    write_in_COM = 1'b0;
  endtask

  task automatic start();
    @(posedge clk_in_COM); #1;
    enable_transfer_mode_REG = 1'b1;
    @(posedge clk_in_COM); #1;
    enable_transfer_mode_REG = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk_in_COM); #1;
    while (busy && n < budget) begin
      @(negedge clk_in_COM); #1;
      n++;
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int n = 0;
    while (pushes < target && n < budget) begin
      @(negedge clk_in_COM); #1;
      n++;
    end
    check("push_wait", 64'(pushes >= target), 64'd1);
  endtask

  task automatic pulse_continue();
    @(posedge clk_in_COM); #1;
    continue_block_gap_REG = 1'b1;
    @(posedge clk_in_COM); #1;
    continue_block_gap_REG = 1'b0;
  endtask

  initial begin
    int base, nd0, dn0, ic0;
    logic [7:0] f0;

    // Reset state
    repeat (2) @(posedge clk_in_COM);
    @(negedge clk_in_COM);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(error_DMA), 64'd0);
    check("rst_strobes", 64'({push_FIFO, pop_FIFO, we_RAM, newDAT_DAT, transfer_complete_DAT}), 64'd0);
    check("rst_addr", addr_out_RAM, 64'd0);
    @(posedge clk_in_COM); #1;
    reset_in_COM = 1'b0;

    // Single tran descriptor, RAM->FIFO
    write_desc(3'd0, 64'h100, 16'd4, 16'h0023);
    for (int i = 0; i < 4; i++) rd_q.push_back({64'h100 + 64'(i), ram_f(64'h100 + 64'(i))});
    base = pushes; nd0 = newdat_cnt; dn0 = done_cnt;
    dir_REG = 1'b1;
    start();
    wait_idle(100);
    check("t1_pushes", 64'(pushes - base), 64'd4);
    check("t1_done", 64'(done_cnt - dn0), 64'd1);
    check("t1_newdat", 64'(newdat_cnt - nd0), 64'd1);
    check("t1_q_empty", 64'(rd_q.size()), 64'd0);

    // nop -> link -> tran, FIFO->RAM with empty toggling
    write_desc(3'd0, 64'h0, 16'd0, 16'h0001);
    write_desc(3'd1, 64'h3, 16'd0, 16'h0031);
    write_desc(3'd3, 64'h200, 16'd2, 16'h0023);
    f0 = fifo_data;
    wr_q.push_back({64'h200, f0});
    wr_q.push_back({64'h201, f0 + 8'd1});
    base = writes; nd0 = newdat_cnt;
    dir_REG = 1'b0; empty_toggle = 1'b1;
    start();
    wait_idle(100);
    empty_toggle = 1'b0;
    check("t2_writes", 64'(writes - base), 64'd2);
    check("t2_newdat", 64'(newdat_cnt - nd0), 64'd3);
    check("t2_q_empty", 64'(wr_q.size()), 64'd0);

    // Block gaps every 2 words over a 5-word descriptor
    write_desc(3'd0, 64'h300, 16'd5, 16'h0023);
    for (int i = 0; i < 5; i++) rd_q.push_back({64'h300 + 64'(i), ram_f(64'h300 + 64'(i))});
    base = pushes;
    dir_REG = 1'b1; block_size_REG = 12'd2; stop_block_gap_REG = 1'b1;
    start();
    wait_pushes(base + 2, 100);
    repeat (5) @(negedge clk_in_COM);
    #1;
    check("t3_gap1_hold", 64'(pushes - base), 64'd2);
    check("t3_gap1_busy", 64'(busy), 64'd1);
    pulse_continue();
    wait_pushes(base + 4, 100);
    repeat (5) @(negedge clk_in_COM);
    #1;
    check("t3_gap2_hold", 64'(pushes - base), 64'd4);
    pulse_continue();
    wait_idle(100);
    check("t3_pushes", 64'(pushes - base), 64'd5);
    block_size_REG = 12'd0; stop_block_gap_REG = 1'b0;

    // Abort at word 3 of 8
    write_desc(3'd0, 64'h400, 16'd8, 16'h0023);
    rd_q.push_back({64'h400, ram_f(64'h400)});
    rd_q.push_back({64'h401, ram_f(64'h401)});
    base = pushes;
    start();
    wait_pushes(base + 2, 100);
    @(posedge clk_in_COM); #1;
    error_in_COM = 1'b1;
    @(negedge clk_in_COM);
    check("t4_no_strobe", 64'(push_FIFO), 64'd0);
    @(posedge clk_in_COM); #1;
    error_in_COM = 1'b0;
    @(negedge clk_in_COM);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_err", 64'(error_DMA), 64'd1);
    repeat (3) @(negedge clk_in_COM);
    check("t4_err_sticky", 64'(error_DMA), 64'd1);
    check("t4_pushes", 64'(pushes - base), 64'd2);

    // Next start clears the sticky error
    write_desc(3'd0, 64'h500, 16'd1, 16'h0023);
    rd_q.push_back({64'h500, ram_f(64'h500)});
    start();
    @(negedge clk_in_COM);
    check("t5_err_cleared", 64'(error_DMA), 64'd0);
    wait_idle(100);
    check("t5_q_empty", 64'(rd_q.size()), 64'd0);

    // Invalid descriptor
    write_desc(3'd0, 64'h600, 16'd3, 16'h0020);
    base = pushes;
    start();
    wait_idle(100);
    check("t6_err", 64'(error_DMA), 64'd1);
    check("t6_pushes", 64'(pushes - base), 64'd0);

    // Reset mid-transfer
    write_desc(3'd0, 64'h700, 16'd8, 16'h0023);
    for (int i = 0; i < 8; i++) rd_q.push_back({64'h700 + 64'(i), ram_f(64'h700 + 64'(i))});
    base = pushes;
    start();
    wait_pushes(base + 2, 100);
    @(posedge clk_in_COM); #1;
    reset_in_COM = 1'b1;
    @(posedge clk_in_COM);
    @(negedge clk_in_COM);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_strobes", 64'({push_FIFO, pop_FIFO, we_RAM, newDAT_DAT, transfer_complete_DAT, int_DAT}), 64'd0);
    check("t7_addr", addr_out_RAM, 64'd0);
    check("t7_data", 64'({data_out_FIFO, data_out_RAM}), 64'd0);
    check("t7_err", 64'(error_DMA), 64'd0);
    @(posedge clk_in_COM); #1;
    reset_in_COM = 1'b0;
    rd_q.delete();

    // Descriptor with int bit
    write_desc(3'd0, 64'h800, 16'd2, 16'h0027);
    rd_q.push_back({64'h800, ram_f(64'h800)});
    rd_q.push_back({64'h801, ram_f(64'h801)});
    ic0 = int_cnt;
    start();
    wait_idle(100);
`ifdef ADMA_INT_EN
    check("t8_int", 64'(int_cnt - ic0), 64'd1);
`else
    check("t8_int", 64'(int_cnt - ic0), 64'd0);
`endif
    check("t8_q_empty", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
